// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the ID-facing
// instruction output and redirect inputs.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        brh;
  logic [31:0] brh_addr;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_ack, imem_rdata, id_ready, brh, brh_addr
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_ack, imem_rdata, id_ready, brh, brh_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential req/ack reads, buffers returns in a
// small prefetch queue and handles ID redirects, draining any in-flight read.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(QDEPTH);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       drain_addr_q, drain_addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       pc_mem   [QDEPTH];
  logic [31:0]       inst_mem [QDEPTH];

  logic        valid;
  logic        redirect;
  logic        push;
  logic        pop;
  logic        req;
  logic [31:0] addr;

  assign valid    = (count_q != '0);
  assign redirect = bus.brh & valid;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    req          = 1'b0;
    addr         = fetch_pc_q;
    push         = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      StRun: begin
        req = rst & (count_q < Full);
        if (redirect) begin
          count_d    = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          fetch_pc_d = bus.brh_addr & 32'hFFFF_FFFC;
          // A read that cannot be withdrawn must complete before the target is fetched
          if (req && !bus.imem_ack) begin
            state_d      = StDrain;
            drain_addr_d = fetch_pc_q;
          end
        end else begin
          push = req & bus.imem_ack;
          pop  = valid & bus.id_ready;
          if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          count_d = count_q + CntW'(push) - CntW'(pop);
        end
      end
      StDrain: begin
        req  = rst;
        addr = drain_addr_q;
        if (bus.imem_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      fetch_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
      drain_addr_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Entry contents need no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign bus.out_inst  = valid ? inst_mem[rd_ptr_q] : NOP_INST;

endmodule
